a_skew_feeder: RTL and testbench
================================

// Module: a_skew_feeder
// PURPOSE
// - Upstream operand feeder for the PE systolic array. Buffers one K-beat tile of A operands.
// - Each beat carries ROWS lanes of VECTOR elements; lane r feeds the a_n_1 edge input of array row r.
// - Replays the tile diagonally: lane r is delayed r cycles behind lane 0, which gives the wavefront alignment the PE grid needs.
// - A shared go strobe starts the replay, so the A feeder and the B feeder launch in lockstep.
// PARAMETERS
// - REG_WIDTH  16  bits per operand element (matches PE)
// - VECTOR     2   elements per lane per beat (matches PE vector width)
// - ROWS       4   array rows fed = number of output lanes (>=1)
// - K          4   beats per tile (reduction depth, >=1)
// PORTS
// - clk        in   1                     rising-edge clock
// - rst        in   1                     asynchronous, active-high reset
// - in_valid   in   1                     upstream beat valid
// - in_ready   out  1                     feeder accepts beat; = (state==LOAD) & ~rst
// - in_data    in   ROWS*VECTOR*REG_WIDTH element (r,v) at [(r*VECTOR+v)*REG_WIDTH +: REG_WIDTH]
// - go         in   1                     start replay of a full buffer (level, sampled)
// - out_data   out  ROWS*VECTOR*REG_WIDTH skewed lanes, same packing as in_data; zero when lane invalid
// - out_valid  out  ROWS                  bit r = lane r carries a tile element this cycle
// - tile_done  out  1                     one-cycle pulse with the last valid beat on lane ROWS-1
// - busy       out  1                     state != LOAD
// BEHAVIOUR
// - Reset (async): state=LOAD, wr_cnt=rd_cnt=drain_cnt=0, all delay regs, out_data, out_valid, tile_done = 0.
//   Buffer RAM contents are don't-care.
// - FSM LOAD -> FULL -> STREAM -> DRAIN -> LOAD.
// - LOAD: a beat is accepted when in_valid&in_ready.
//   - buf[wr_cnt] <= in_data; wr_cnt++.
//   - The K-th accept moves to FULL and clears wr_cnt. Gaps in in_valid are allowed.
// - FULL: in_ready=0. go=1 sampled at edge T0 moves to STREAM. go in any other state is ignored
//   (this includes go in the same cycle as the K-th accept).
// - STREAM: lasts K cycles; lane-0 launch register loads buf[rd_cnt]; rd_cnt++.
// - DRAIN: lasts ROWS-1 cycles (skipped if ROWS==1), then returns to LOAD.
// - Timing (cycle T0 = the cycle go is sampled in FULL):
//   - In cycle T0+1+r+k, lane r presents buf[k] lane r with out_valid[r]=1, for k=0..K-1.
//   - Outside that window, lane r shows out_data=0 and out_valid[r]=0.
//   - tile_done=1 only in cycle T0+K+ROWS-1. in_ready=1 again from cycle T0+K+ROWS.
// - Lane r skew = r register stages behind lane 0. Data and valid travel together, and the stages are always enabled.
// - Zero-fill is mandatory: PEs have no enable, so every invalid slot must multiply as zero.
// - No stall during STREAM/DRAIN; the array cannot pause. in_valid in FULL/STREAM/DRAIN is not accepted and is not lost upstream.
// - Pure pass-through: no arithmetic, no width change. Counters are $clog2(K+1) bits and never wrap past K-1.
// - rst mid-LOAD: partial tile discarded.
// - rst mid-STREAM/DRAIN: outputs zero immediately and the tile is aborted; no tile_done.
// - After reset release, the next in_valid starts a fresh tile.
// TESTING (ROWS=4, VECTOR=2, K=4; element(k,r,v)=16'h0000|k<<8|r<<4|v)
// - Basic: 4 contiguous beats, go at T0.
//   - lane0 valid T0+1..T0+4 (k=0..3); lane3 valid T0+4..T0+7.
//   - tile_done at T0+7 only; in_ready=1 at T0+8.
// - Gappy load: in_valid every other cycle. in_ready stays 1 until the 4th accept; outputs identical to Basic.
// - go early: go held high from reset. Replay starts the cycle after FULL is entered (not on the 4th-accept cycle); timing matches Basic relative to that.
// - Backpressure: in_valid=1 with new data during STREAM. in_ready=0, no write, buffer unchanged; the beat is accepted at T0+8.
// - Mid-stream reset: rst at T0+3.
//   - out_valid=0 and out_data=0 the same cycle; no tile_done.
//   - After release, in_ready=1 and a new tile replays correctly.
// - Back-to-back: second tile loaded from T0+8 and go right after FULL.
//   - Lane timing repeats with no stale data.
//   - Invalid slots between tiles are zero on all lanes.

Source files
------------

// File: rtl/a_skew_feeder.sv
// a_skew_feeder: buffers one K-beat tile of A operands and replays it with lane r
// delayed r cycles behind lane 0, zero-filling every slot that carries no element.
module a_skew_feeder #(
  parameter int REG_WIDTH = 16,
  parameter int VECTOR    = 2,
  parameter int ROWS      = 4,
  parameter int K         = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ROWS*VECTOR*REG_WIDTH-1:0]  in_data,
  input  logic                              go,
  output logic [ROWS*VECTOR*REG_WIDTH-1:0]  out_data,
  output logic [ROWS-1:0]                   out_valid,
  output logic                              tile_done,
  output logic                              busy
);
  localparam int LW = VECTOR * REG_WIDTH;
  localparam int BW = ROWS * LW;
  localparam int CW = $clog2(K + 1);
  localparam int AW = K > 1 ? $clog2(K) : 1;
  localparam int DW = ROWS > 2 ? $clog2(ROWS - 1) : 1;
  localparam logic [CW-1:0] KM1  = CW'(K - 1);
  localparam logic [AW-1:0] AKM1 = AW'(K - 1);
  localparam logic [DW-1:0] DM   = DW'(ROWS > 1 ? ROWS - 2 : 0);

  typedef enum logic [1:0] {LOAD, FULL, STREAM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [ROWS-1:0] last_q, last_d;
  logic [AW-1:0]   rd_idx;
  logic            launch, launch_last;
  logic [BW-1:0]   beat;
  logic [BW-1:0]   mem_q [K];

  assign in_ready    = (state_q == LOAD) & ~rst;
  assign busy        = state_q != LOAD;
  assign beat        = mem_q[rd_idx];
  assign launch_last = launch && rd_idx == AKM1;
  assign tile_done   = last_q[ROWS-1];

  // The go edge launches beat 0; each STREAM cycle but the last launches the next beat.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    drain_cnt_d = drain_cnt_q;
    launch      = 1'b0;
    rd_idx      = '0;
    case (state_q)
      LOAD: if (in_valid) begin
        state_d  = wr_cnt_q == KM1 ? FULL : LOAD;
        wr_cnt_d = wr_cnt_q == KM1 ? '0 : wr_cnt_q + 1'b1;
      end
      FULL: if (go) begin
        state_d = STREAM;
        launch  = 1'b1;
      end
      STREAM: begin
        launch   = rd_cnt_q != KM1;
        rd_idx   = rd_cnt_q[AW-1:0] + 1'b1;
        rd_cnt_d = rd_cnt_q == KM1 ? '0 : rd_cnt_q + 1'b1;
        if (rd_cnt_q == KM1) begin
          if (ROWS > 1) state_d = DRAIN;
          else state_d = LOAD;
        end
      end
      default: begin
        drain_cnt_d = drain_cnt_q == DM ? '0 : drain_cnt_q + 1'b1;
        if (drain_cnt_q == DM) state_d = LOAD;
      end
    endcase
  end

  always_comb begin
    last_d[0] = launch_last;
    for (int s = 1; s < ROWS; s++) last_d[s] = last_q[s-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      drain_cnt_q <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      last_q      <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) mem_q[wr_cnt_q[AW-1:0]] <= in_data;
  end

  // Lane r owns a private r+1 deep delay line so data and valid stay aligned.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [LW-1:0] d_q [r+1];
    logic [LW-1:0] d_d [r+1];
    logic [r:0]    v_q, v_d;
    always_comb begin
      d_d[0] = launch ? beat[r*LW +: LW] : '0;
      v_d[0] = launch;
      for (int s = 1; s <= r; s++) begin
        d_d[s] = d_q[s-1];
        v_d[s] = v_q[s-1];
      end
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d_q <= '{default: '0};
        v_q <= '0;
      end else begin
        d_q <= d_d;
        v_q <= v_d;
      end
    end
    assign out_data[r*LW +: LW] = d_q[r];
    assign out_valid[r]         = v_q[r];
  end
endmodule

// File: tb/tb_a_skew_feeder.sv
// tb_a_skew_feeder: directed and random steps checked every cycle against a
// timing-window model of the skewed replay.
module tb_a_skew_feeder;
  localparam int W = 16, V = 2, R = 4, K = 4;
  localparam int LW = V * W, DW = R * LW;

  logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, go = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, tile_done, busy;
  logic [DW-1:0] out_data;
  logic [R-1:0]  out_valid;

  a_skew_feeder #(.REG_WIDTH(W), .VECTOR(V), .ROWS(R), .K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .go(go), .out_data(out_data), .out_valid(out_valid), .tile_done(tile_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, t0 = -1, cnt = 0;
  bit full = 1'b0;
  logic [DW-1:0] mem [K];
  logic [DW-1:0] tile [K];

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] b;
    for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [DW-1:0] pat_beat(int k);
    logic [DW-1:0] b;
    for (int r = 0; r < R; r++)
      for (int v = 0; v < V; v++) b[(r*V+v)*W +: W] = 16'((k << 8) | (r << 4) | v);
    return b;
  endfunction

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic mreset();
    cnt = 0; full = 1'b0; t0 = -1;
  endtask

  task automatic check_outputs();
    logic [DW-1:0] ed;
    logic [R-1:0]  ev;
    ed = '0; ev = '0;
    for (int r = 0; r < R; r++) begin
      int k = cyc - t0 - 1 - r;
      if (t0 >= 0 && k >= 0 && k < K) begin
        ev[r] = 1'b1;
        ed[r*LW +: LW] = tile[k][r*LW +: LW];
      end
    end
    chk("out_data", out_data, ed);
    chk("out_valid", DW'(out_valid), DW'(ev));
    chk("tile_done", DW'(tile_done), DW'(t0 >= 0 && cyc == t0 + K + R - 1));
    chk("in_ready", DW'(in_ready), DW'(!rst && !full && t0 < 0));
    chk("busy", DW'(busy), DW'(full || t0 >= 0));
  endtask

  task automatic step();
    if (rst) mreset();
    else if (full && go) begin
      t0 = cyc; full = 1'b0; tile = mem;
    end else if (!full && t0 < 0 && in_valid) begin
      mem[cnt] = in_data;
      cnt++;
      if (cnt == K) begin full = 1'b1; cnt = 0; end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (t0 >= 0 && cyc >= t0 + K + R) t0 = -1;
    check_outputs();
  endtask

  task automatic load(bit gappy, bit pat);
    for (int k = 0; k < K; k++) begin
      in_valid = 1'b1;
      in_data = pat ? pat_beat(k) : rnd_beat();
      step();
      if (gappy) begin
        in_valid = 1'b0;
        in_data = rnd_beat();
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic fire();
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  initial begin
    #1;
    check_outputs();
    repeat (3) step();
    rst = 1'b0;
    step();
    // basic tile with the element pattern, then idle through the full replay
    load(1'b0, 1'b1);
    step();
    fire();
    repeat (K + R + 2) step();
    // gappy load
    load(1'b1, 1'b0);
    fire();
    repeat (K + R + 2) step();
    // go held high from before the load
    go = 1'b1;
    load(1'b0, 1'b0);
    repeat (K + R + 2) step();
    go = 1'b0;
    step();
    // upstream keeps offering beats during replay; they wait for LOAD
    load(1'b0, 1'b0);
    fire();
    in_valid = 1'b1;
    repeat (K + R + K + 1) begin
      in_data = rnd_beat();
      step();
    end
    in_valid = 1'b0;
    fire();
    repeat (K + R + 2) step();
    // asynchronous reset in the middle of a replay
    load(1'b0, 1'b0);
    fire();
    repeat (2) step();
    #1 rst = 1'b1;
    #1 mreset();
    check_outputs();
    repeat (2) step();
    rst = 1'b0;
    step();
    load(1'b0, 1'b0);
    fire();
    repeat (K + R + 2) step();
    // back-to-back tiles with go right after FULL
    repeat (2) begin
      load(1'b0, 1'b0);
      fire();
      repeat (K + R) step();
    end
    repeat (3) step();
    // random traffic
    repeat (400) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = rnd_beat();
      go = ($urandom_range(0, 3) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
